// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU region decoder: FSM states,
// default region map and the lowest-index priority helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Widest region count supported; helpers operate at this width.
    localparam int MAX_REG = 16;

    // Default map: regions 0/1 disabled, region 2 = 0x2000-0x3FFF, region 3 = 0x7000-0x70FF.
    localparam logic [4*32-1:0] DEF_REGION_BASE = {32'h0000_7000, 32'h0000_2000, 32'h0, 32'h0};
    localparam logic [4*32-1:0] DEF_REGION_MASK = {32'h0000_FF00, 32'h0000_E000, 32'h0, 32'h0};

    // Isolates the lowest set bit so overlapping regions resolve to the lowest index.
    function automatic logic [MAX_REG-1:0] onehot_first(input logic [MAX_REG-1:0] match);
        return match & (~match + MAX_REG'(1));
    endfunction

endpackage

// File: rtl/lsu_region_match.sv
// Combinational base/mask compare across all regions; yields the raw match
// vector, the lowest-index one-hot hit and an any-hit flag.
module lsu_region_match
    import lsu_pkg::*;
#(
    parameter int                      ADDR_W      = 32,
    parameter int                      N_REG       = 4,
    parameter logic [N_REG*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [N_REG*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N_REG-1:0]  match_o,
    output logic [N_REG-1:0]  hit_o,
    output logic              any_hit_o
);

    always_comb begin
        match_o = '0;
        for (int i = 0; i < N_REG; i++) begin
            // A zero mask would match every address, so it marks the region disabled.
            match_o[i] = (REGION_MASK[i*ADDR_W +: ADDR_W] != '0) &&
                         ((addr_i & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]);
        end
    end

    assign hit_o     = N_REG'(onehot_first(MAX_REG'(match_o)));
    assign any_hit_o = |match_o;

endmodule

// File: rtl/lsu_region_decode.sv
// Registered LSU address decoder and transaction sequencer: decodes a request
// to one of N_REG targets, runs a req/ack handshake with timeout, reports errors.
module lsu_region_decode
    import lsu_pkg::*;
#(
    parameter int                      ADDR_W      = 32,
    parameter int                      DATA_W      = 32,
    parameter int                      N_REG       = 4,
    parameter logic [N_REG*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
    parameter logic [N_REG*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
    parameter logic [N_REG-1:0]        REGION_WO   = 4'b0011,
    parameter int                      TIMEOUT     = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_lsu_req,
    input  logic [ADDR_W-1:0]       i_lsu_addr,
    input  logic                    i_lsu_wren,
    input  logic [DATA_W-1:0]       i_lsu_wdata,
    output logic                    o_lsu_busy,
    output logic                    o_lsu_ack,
    output logic                    o_lsu_err,
    output logic [DATA_W-1:0]       o_lsu_rdata,
    output logic [N_REG-1:0]        o_reg_sel,
    output logic                    o_reg_wren,
    output logic [ADDR_W-1:0]       o_reg_addr,
    output logic [DATA_W-1:0]       o_reg_wdata,
    input  logic [N_REG-1:0]        i_reg_ack,
    input  logic [N_REG*DATA_W-1:0] i_reg_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e          state_q, state_d;
    logic [N_REG-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [N_REG-1:0]    match;
    logic [N_REG-1:0]    hit;
    logic                any_hit;
    logic                wo_read;
    logic                target_ack;
    logic [DATA_W-1:0]   sel_rdata;

    lsu_region_match #(
        .ADDR_W      (ADDR_W),
        .N_REG       (N_REG),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_match (
        .addr_i    (i_lsu_addr),
        .match_o   (match),
        .hit_o     (hit),
        .any_hit_o (any_hit)
    );

    // The priority pick must be a one-hot subset of the raw matches.
    always_comb begin
        assert (((hit & ~match) == '0) && $onehot0(hit));
    end

    assign wo_read    = !i_lsu_wren && |(hit & REGION_WO);
    assign target_ack = |(i_reg_ack & sel_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (sel_q[i]) sel_rdata = sel_rdata | i_reg_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path can infer a latch.
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        wren_d  = wren_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (i_lsu_req) begin
                    wren_d  = i_lsu_wren;
                    addr_d  = i_lsu_addr;
                    wdata_d = i_lsu_wdata;
                    if (any_hit && !wo_read) begin
                        sel_d   = hit;
                        state_d = BUSY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack takes priority, so an ack on the final allowed cycle still succeeds.
                if (target_ack) begin
                    sel_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = wren_q ? '0 : sel_rdata;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    sel_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = IDLE;
            end
            default: begin
                sel_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign o_lsu_busy  = (state_q != IDLE);
    assign o_lsu_ack   = (state_q == RESP);
    assign o_lsu_err   = err_q;
    assign o_lsu_rdata = rdata_q;
    assign o_reg_sel   = sel_q;
    assign o_reg_wren  = wren_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_region_decode.sv
// Self-checking bench for lsu_region_decode: directed vector table, reset and
// back-to-back sequences, then random transactions against a behavioural model.
module tb_lsu_region_decode;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int N_REG   = 4;
    localparam int TIMEOUT = 15;

    // Regions 0 and 1 enabled here (write-only, overlapping) so the write-only
    // and lowest-index-wins rules are observable; regions 2/3 keep the default map.
    localparam logic [N_REG*ADDR_W-1:0] TB_BASE = {32'h0000_7000, 32'h0000_2000, 32'h0000_4000, 32'h0000_4000};
    localparam logic [N_REG*ADDR_W-1:0] TB_MASK = {32'h0000_FF00, 32'h0000_E000, 32'h0000_FF00, 32'h0000_F000};
    localparam logic [N_REG-1:0]        TB_WO   = 4'b0011;

    logic                    i_clk;
    logic                    i_rst_n;
    logic                    i_lsu_req;
    logic [ADDR_W-1:0]       i_lsu_addr;
    logic                    i_lsu_wren;
    logic [DATA_W-1:0]       i_lsu_wdata;
    logic                    o_lsu_busy;
    logic                    o_lsu_ack;
    logic                    o_lsu_err;
    logic [DATA_W-1:0]       o_lsu_rdata;
    logic [N_REG-1:0]        o_reg_sel;
    logic                    o_reg_wren;
    logic [ADDR_W-1:0]       o_reg_addr;
    logic [DATA_W-1:0]       o_reg_wdata;
    logic [N_REG-1:0]        i_reg_ack;
    logic [N_REG*DATA_W-1:0] i_reg_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_region_decode #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .N_REG       (N_REG),
        .REGION_BASE (TB_BASE),
        .REGION_MASK (TB_MASK),
        .REGION_WO   (TB_WO),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_lsu_req   (i_lsu_req),
        .i_lsu_addr  (i_lsu_addr),
        .i_lsu_wren  (i_lsu_wren),
        .i_lsu_wdata (i_lsu_wdata),
        .o_lsu_busy  (o_lsu_busy),
        .o_lsu_ack   (o_lsu_ack),
        .o_lsu_err   (o_lsu_err),
        .o_lsu_rdata (o_lsu_rdata),
        .o_reg_sel   (o_reg_sel),
        .o_reg_wren  (o_reg_wren),
        .o_reg_addr  (o_reg_addr),
        .o_reg_wdata (o_reg_wdata),
        .i_reg_ack   (i_reg_ack),
        .i_reg_rdata (i_reg_rdata)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic        wren;
        logic [31:0] wdata;
        int          ack_k;    // BUSY cycle in which the target acks; 0 = never
        logic [31:0] rd_val;
        logic        spur;     // spurious reqs and foreign acks while busy
        logic [3:0]  exp_sel;
        logic        exp_err;
    } vec_t;

    vec_t vecs [0:11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"},  128'(o_lsu_busy),  128'(0));
        check({tag, " ack"},   128'(o_lsu_ack),   128'(0));
        check({tag, " err"},   128'(o_lsu_err),   128'(0));
        check({tag, " rdata"}, 128'(o_lsu_rdata), 128'(0));
        check({tag, " sel"},   128'(o_reg_sel),   128'(0));
        check({tag, " wren"},  128'(o_reg_wren),  128'(0));
        check({tag, " addr"},  128'(o_reg_addr),  128'(0));
        check({tag, " wdata"}, 128'(o_reg_wdata), 128'(0));
    endtask

    // Reference decode: scan regions from index 0, first enabled match wins.
    task automatic model_decode(input logic [31:0] addr, input logic wren,
                                output logic [3:0] sel, output logic dec_err);
        int idx;
        idx = -1;
        for (int i = 0; i < N_REG; i++) begin
            logic [31:0] b, m;
            b = TB_BASE[i*32 +: 32];
            m = TB_MASK[i*32 +: 32];
            if (idx < 0 && m != 0 && (addr & m) == b) idx = i;
        end
        if (idx < 0) begin
            sel = 4'b0000;
            dec_err = 1'b1;
        end else if (!wren && TB_WO[idx]) begin
            sel = 4'b0000;
            dec_err = 1'b1;
        end else begin
            sel = 4'(1 << idx);
            dec_err = 1'b0;
        end
    endtask

    // Entered at a negedge with the DUT idle; leaves at the negedge of the idle
    // cycle after RESP, so the next call issues a back-to-back request.
    task automatic run_txn(input vec_t v, input string tag);
        int          lat;
        logic [31:0] exp_rd;
        if (v.exp_sel == 0)                           lat = 2;
        else if (v.ack_k >= 1 && v.ack_k <= TIMEOUT)  lat = v.ack_k + 2;
        else                                          lat = TIMEOUT + 2;
        exp_rd = (!v.exp_err && !v.wren) ? v.rd_val : 32'h0;

        i_lsu_req   = 1'b1;
        i_lsu_addr  = v.addr;
        i_lsu_wren  = v.wren;
        i_lsu_wdata = v.wdata;
        i_reg_ack   = '0;
        i_reg_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};

        for (int c = 2; c <= lat + 1; c++) begin
            @(negedge i_clk);
            if (c < lat) begin
                check($sformatf("%s c%0d busy", tag, c),  128'(o_lsu_busy),  128'(1));
                check($sformatf("%s c%0d ack", tag, c),   128'(o_lsu_ack),   128'(0));
                check($sformatf("%s c%0d sel", tag, c),   128'(o_reg_sel),   128'(v.exp_sel));
                check($sformatf("%s c%0d wren", tag, c),  128'(o_reg_wren),  128'(v.wren));
                check($sformatf("%s c%0d addr", tag, c),  128'(o_reg_addr),  128'(v.addr));
                check($sformatf("%s c%0d wdata", tag, c), 128'(o_reg_wdata), 128'(v.wdata));
            end else if (c == lat) begin
                check($sformatf("%s resp ack", tag),   128'(o_lsu_ack),   128'(1));
                check($sformatf("%s resp err", tag),   128'(o_lsu_err),   128'(v.exp_err));
                check($sformatf("%s resp rdata", tag), 128'(o_lsu_rdata), 128'(exp_rd));
                check($sformatf("%s resp busy", tag),  128'(o_lsu_busy),  128'(1));
                check($sformatf("%s resp sel", tag),   128'(o_reg_sel),   128'(0));
                check($sformatf("%s resp addr", tag),  128'(o_reg_addr),  128'(v.addr));
            end else begin
                check($sformatf("%s post busy", tag),  128'(o_lsu_busy),  128'(0));
                check($sformatf("%s post ack", tag),   128'(o_lsu_ack),   128'(0));
                check($sformatf("%s post err", tag),   128'(o_lsu_err),   128'(0));
                check($sformatf("%s post rdata", tag), 128'(o_lsu_rdata), 128'(0));
                check($sformatf("%s post sel", tag),   128'(o_reg_sel),   128'(0));
            end

            if (v.spur && c <= lat) begin
                i_lsu_req   = 1'b1;
                i_lsu_addr  = $urandom();
                i_lsu_wren  = 1'($urandom());
                i_lsu_wdata = $urandom();
                i_reg_ack   = 4'($urandom()) & ~v.exp_sel;
            end else begin
                i_lsu_req = 1'b0;
                i_reg_ack = '0;
            end
            i_reg_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (v.exp_sel != 0 && c - 1 == v.ack_k) begin
                i_reg_ack = i_reg_ack | v.exp_sel;
                for (int i = 0; i < N_REG; i++) begin
                    if (v.exp_sel[i]) i_reg_rdata[i*32 +: 32] = v.rd_val;
                end
            end
        end
        i_lsu_req = 1'b0;
        i_reg_ack = '0;
    endtask

    initial begin
        vec_t        rv;
        logic [3:0]  m_sel;
        logic        m_derr;

        //           addr         wren  wdata          ack_k rd_val        spur  exp_sel  exp_err
        vecs[0]  = '{32'h0000_7004, 1'b1, 32'hA5A5_A5A5,  2, 32'h0,         1'b0, 4'b1000, 1'b0};
        vecs[1]  = '{32'h0000_2010, 1'b0, 32'h0,          1, 32'hDEAD_BEEF, 1'b0, 4'b0100, 1'b0};
        vecs[2]  = '{32'h0000_9000, 1'b0, 32'h0,          0, 32'h0,         1'b0, 4'b0000, 1'b1};
        vecs[3]  = '{32'h0000_4010, 1'b0, 32'h0,          1, 32'h1111_2222, 1'b0, 4'b0000, 1'b1};
        vecs[4]  = '{32'h0000_2000, 1'b1, 32'h0BAD_0BAD,  0, 32'h0,         1'b0, 4'b0100, 1'b1};
        vecs[5]  = '{32'h0000_2000, 1'b1, 32'h600D_600D, 15, 32'h0,         1'b0, 4'b0100, 1'b0};
        vecs[6]  = '{32'h0000_4010, 1'b1, 32'h0000_4010,  1, 32'h0,         1'b0, 4'b0001, 1'b0};
        vecs[7]  = '{32'h0000_4800, 1'b1, 32'h4800_4800,  3, 32'h0,         1'b1, 4'b0001, 1'b0};
        vecs[8]  = '{32'h0000_7000, 1'b0, 32'h0,          3, 32'h1234_5678, 1'b1, 4'b1000, 1'b0};
        vecs[9]  = '{32'h0000_9000, 1'b1, 32'h9999_9999,  1, 32'h0,         1'b1, 4'b0000, 1'b1};
        vecs[10] = '{32'h0000_3FFC, 1'b0, 32'h0,         14, 32'hCAFE_F00D, 1'b1, 4'b0100, 1'b0};
        vecs[11] = '{32'h0000_2004, 1'b0, 32'h0,         16, 32'h5555_AAAA, 1'b0, 4'b0100, 1'b1};

        i_rst_n     = 1'b0;
        i_lsu_req   = 1'b0;
        i_lsu_addr  = '0;
        i_lsu_wren  = 1'b0;
        i_lsu_wdata = '0;
        i_reg_ack   = '0;
        i_reg_rdata = '0;
        repeat (2) @(negedge i_clk);
        check_zero("reset");
        i_rst_n = 1'b1;

        for (int n = 0; n < 12; n++) run_txn(vecs[n], $sformatf("vec%0d", n));

        // Reset in the middle of a BUSY phase aborts without any ack pulse.
        i_lsu_req   = 1'b1;
        i_lsu_addr  = 32'h0000_7004;
        i_lsu_wren  = 1'b1;
        i_lsu_wdata = 32'h0000_0011;
        @(negedge i_clk);
        i_lsu_req = 1'b0;
        @(negedge i_clk);
        check("rstmid pre busy", 128'(o_lsu_busy), 128'(1));
        check("rstmid pre sel",  128'(o_reg_sel),  128'(4'b1000));
        #1 i_rst_n = 1'b0;
        #1 check_zero("rstmid async");
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check($sformatf("rstmid hold%0d ack", k), 128'(o_lsu_ack), 128'(0));
        end
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rstmid released busy", 128'(o_lsu_busy), 128'(0));
        run_txn(vecs[1], "after_rst");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       rv.addr = 32'h0000_2000 | ($urandom() & 32'h1FFF);
                1:       rv.addr = 32'h0000_7000 | ($urandom() & 32'h00FF);
                2:       rv.addr = 32'h0000_4000 | ($urandom() & 32'h0FFF);
                3:       rv.addr = $urandom() & 32'hFFFF;
                default: rv.addr = $urandom();
            endcase
            rv.wren   = 1'($urandom());
            rv.wdata  = $urandom();
            rv.ack_k  = int'($urandom_range(0, TIMEOUT + 2));
            rv.rd_val = $urandom();
            rv.spur   = 1'($urandom());
            model_decode(rv.addr, rv.wren, m_sel, m_derr);
            rv.exp_sel = m_sel;
            rv.exp_err = m_derr || (rv.ack_k < 1 || rv.ack_k > TIMEOUT);
            run_txn(rv, $sformatf("rnd%0d", n));
            if ($urandom_range(0, 1) == 1) @(negedge i_clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_region_decode.md
Name: lsu_region_decode

Overview:
Parametrised, registered LSU address decoder and transaction sequencer. It generalises the fixed two-target write-enable decode to N_REG base/mask regions, handles both reads and writes, and drives a per-region request/ack handshake. Unmapped accesses, illegal accesses and timeouts are reported as bus errors. It sits between the LSU and the peripheral/buffer targets (output buffer, SDRAM buffer, further targets).

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
N_REG, 4, number of target regions (1..16)
REGION_BASE, {0x0,0x0,0x2000,0x7000}, packed N_REG*ADDR_W; region i base, entry 0 = LSB slice
REGION_MASK, {0x0,0x0,0xE000,0xFF00}, packed N_REG*ADDR_W; region i matches when (addr & MASK_i) == BASE_i; MASK_i == 0 means region disabled
REGION_WO, 4'b0011, bit i = 1: region i is write-only, so a read to it is an error
TIMEOUT, 15, max BUSY cycles waiting for a target ack (>= 1)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_lsu_req  in  1  one-cycle request strobe; sampled only when o_lsu_busy = 0
i_lsu_addr  in  ADDR_W  request address
i_lsu_wren  in  1  1 = write, 0 = read
i_lsu_wdata  in  DATA_W  write data
o_lsu_busy  out  1  high in every state except IDLE
o_lsu_ack  out  1  one-cycle completion pulse
o_lsu_err  out  1  valid with o_lsu_ack; 1 = unmapped, illegal or timeout
o_lsu_rdata  out  DATA_W  read data, valid with o_lsu_ack on a read with err = 0, else 0
o_reg_sel  out  N_REG  one-hot target select, held for the whole BUSY state
o_reg_wren  out  1  registered copy of i_lsu_wren
o_reg_addr  out  ADDR_W  registered copy of i_lsu_addr
o_reg_wdata  out  DATA_W  registered copy of i_lsu_wdata
i_reg_ack  in  N_REG  per-target completion
i_reg_rdata  in  N_REG*DATA_W  per-target read data

Behaviour:
- Reset (async, i_rst_n = 0): FSM = IDLE; all outputs 0; timeout counter 0. Reset asserted mid-transaction aborts it; no ack is issued.
- Match: match_i = (addr & MASK_i) == BASE_i && MASK_i != 0. On overlap the lowest index wins. The select is always one-hot or zero.
- IDLE: when i_lsu_req = 1, latch addr/wren/wdata into o_reg_*.
  - Mapped and legal: o_reg_sel = onehot(hit) from the next cycle, then go to BUSY.
  - No hit, or read to a REGION_WO region: o_reg_sel stays 0, go to RESP with err = 1.
- BUSY: the timeout counter increments each cycle.
  - i_reg_ack[hit] = 1: capture i_reg_rdata slice (0 for writes), go to RESP with err = 0. This is checked before timeout; ack on the timeout cycle counts as success.
  - Else if counter == TIMEOUT-1: go to RESP with err = 1 and rdata = 0.
  - Acks on non-selected bits are ignored.
- RESP (one cycle): o_lsu_ack = 1 with o_lsu_err/o_lsu_rdata. o_reg_sel = 0 and the counter clears. Next state is IDLE.
- o_lsu_ack, o_lsu_err and o_lsu_rdata return to 0 in the cycle after RESP.
- Latency: mapped access = 1 (decode) + k (ack in k-th BUSY cycle, k >= 1) + RESP. An ack in the first BUSY cycle gives o_lsu_ack 3 cycles after the req edge. An unmapped access gives o_lsu_ack 2 cycles after req.
- i_lsu_req while o_lsu_busy = 1 is dropped with no side effect. A req in the IDLE cycle right after RESP is accepted (back-to-back).
- Counter width: clog2(TIMEOUT+1); it must not wrap.

Decomposition:
- Package lsu_pkg holds the FSM state enum (IDLE, BUSY, RESP), default region BASE/MASK constants, and a function onehot_first(match) returning the lowest set bit.
- One sub-module, lsu_region_match: combinational base/mask compare over N_REG producing match vector, hit one-hot and any_hit.
- FSM, latches, counter and rdata mux stay in the top module.

Test Plan:
- Write 0x7004, wdata 0xA5A5A5A5; target 3 acks in the 2nd BUSY cycle -> o_reg_sel = 4'b1000 and o_reg_wren = 1 during BUSY; o_lsu_ack = 1, err = 0 four cycles after req; busy clears the next cycle.
- Read 0x2010; target 2 returns 0xDEADBEEF with immediate ack -> o_reg_sel = 4'b0100; o_lsu_ack with rdata 0xDEADBEEF, err = 0, 3 cycles after req.
- Read 0x9000 (no hit) -> o_reg_sel never asserted; ack + err = 1 two cycles after req; rdata = 0. Repeat with a read to a REGION_WO region and expect the same result.
- Write 0x2000 with target 2 silent, TIMEOUT = 15 -> o_reg_sel held for exactly 15 BUSY cycles; then ack + err = 1. Separately, ack arriving on cycle 15 -> err = 0.
- Req pulses during BUSY plus spurious i_reg_ack[0] -> no effect on state or outputs; a back-to-back req in the IDLE cycle after RESP is accepted.
- Assert i_rst_n = 0 mid-BUSY -> all outputs 0 immediately; no ack pulse; the next request after reset completes normally.
